// File: rtl/branch_predict_resolve.sv
// Branch predictor and resolver: a PC-indexed table of saturating counters,
// a one-cycle registered prediction for fetch, and branch resolution at
// execute, with training, mispredict flagging and performance counters.
module branch_predict_resolve #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CTR_W = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  output logic             pred_vld_o,
  input  logic             ex_valid,
  input  logic [3:0]       ex_ctrl,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_data1,
  input  logic [XLEN-1:0]  ex_data2,
  input  logic [2:0]       ex_func3,
  input  logic             ex_pred_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic [3:0]       res_type,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  typedef enum logic [3:0] {
    CTRL_COND = 4'b0001,
    CTRL_JAL  = 4'b0010,
    CTRL_JALR = 4'b0100,
    CTRL_NONE = 4'b1000
  } ctrl_e;

  logic [CTR_W-1:0] table_q [DEPTH];

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             is_cond;
  logic             is_jump;
  logic             is_branch;
  logic             legal_f3;
  logic             cond_true;
  logic             act_taken;
  logic             act_mp;
  logic             train;

  // Address bits outside the index field carry no information for the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign ex_idx   = ex_pc[IDX_W+1:2];

  // Decode the EX instruction and evaluate its actual outcome.
  always_comb begin
    is_cond   = (ex_ctrl == CTRL_COND);
    is_jump   = (ex_ctrl == CTRL_JAL) || (ex_ctrl == CTRL_JALR);
    is_branch = is_cond || is_jump;
    legal_f3  = 1'b1;
    cond_true = 1'b0;
    case (ex_func3)
      3'b000:  cond_true = (ex_data1 == ex_data2);
      3'b001:  cond_true = (ex_data1 != ex_data2);
      3'b100:  cond_true = ($signed(ex_data1) <  $signed(ex_data2));
      3'b101:  cond_true = ($signed(ex_data1) >= $signed(ex_data2));
      3'b110:  cond_true = (ex_data1 <  ex_data2);
      3'b111:  cond_true = (ex_data1 >= ex_data2);
      default: legal_f3  = 1'b0;
    endcase
    act_taken = is_jump || (is_cond && legal_f3 && cond_true);
    act_mp    = is_branch && (act_taken != ex_pred_taken);
    train     = ex_valid && is_cond && legal_f3;
  end

  // Counter table: training at resolve; lookups elsewhere see the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) table_q[i] <= CTR_INIT;
    end else if (train) begin
      if (act_taken) begin
        if (table_q[ex_idx] != CTR_MAX) table_q[ex_idx] <= table_q[ex_idx] + CTR_W'(1);
      end else begin
        if (table_q[ex_idx] != '0) table_q[ex_idx] <= table_q[ex_idx] - CTR_W'(1);
      end
    end
  end

  // Registered prediction; holds its last value between lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_taken <= 1'b0;
      pred_vld_o <= 1'b0;
    end else begin
      pred_vld_o <= pred_valid;
      if (pred_valid) pred_taken <= table_q[pred_idx][CTR_W-1];
    end
  end

  // Registered resolution results, all zero for an empty EX slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_taken  <= 1'b0;
      res_type   <= '0;
      mispredict <= 1'b0;
    end else begin
      res_valid  <= ex_valid;
      res_taken  <= ex_valid && act_taken;
      res_type   <= ex_valid ? ex_ctrl : '0;
      mispredict <= ex_valid && act_mp;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count <= '0;
      mp_count <= '0;
    end else if (ex_valid) begin
      if (is_branch && (br_count != '1)) br_count <= br_count + CNT_W'(1);
      if (act_mp && (mp_count != '1))    mp_count <= mp_count + CNT_W'(1);
    end
  end

endmodule
